// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I word and instruction-queue entry types
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  // One instruction-queue slot: fetched word tagged with its PC
  typedef struct packed {
    rv32i_word pc;
    rv32i_word instr;
  } iq_entry_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - front-end fetch stage: one outstanding word request, pushes into the iq
module fetch_unit
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_mem_resp,
  input  logic [31:0] instr_mem_rdata,
  output logic        instr_read,
  output logic [31:0] instr_mem_address,
  input  logic        iq_full,
  output logic        iq_push,
  output logic [31:0] iq_instr,
  output logic [31:0] iq_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

  fetch_state_t state, state_next;
  rv32i_word    pc, pc_next;
  rv32i_word    req_addr, req_addr_next;
  rv32i_word    redirect_target;
  iq_entry_t    entry;

  // Redirect targets are word aligned; low two bits are dropped
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // State, fetch PC and outstanding-request address; reset wins over any redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      req_addr <= req_addr_next;
    end
  end

  // Next-state logic: issue from IDLE, complete or abandon in REQ, drain in DROP
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    case (state)
      IDLE: begin
        // A stale response arriving here is simply ignored
        if (redirect_valid) begin
          pc_next = redirect_target;
        end else if (!iq_full) begin
          req_addr_next = pc;
          state_next    = REQ;
        end
      end
      REQ: begin
        if (instr_mem_resp) begin
          state_next = IDLE;
          pc_next    = redirect_valid ? redirect_target : pc + 32'd4;
        end else if (redirect_valid) begin
          // The memory still owes us a word at req_addr, so keep asking for it
          pc_next    = redirect_target;
          state_next = DROP;
        end
      end
      DROP: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
        end
        if (instr_mem_resp) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign entry.pc    = req_addr;
  assign entry.instr = instr_mem_rdata;

  assign instr_read        = (state != IDLE);
  assign instr_mem_address = req_addr;
  assign iq_push           = (state == REQ) & instr_mem_resp & ~redirect_valid;
  assign iq_instr          = entry.instr;
  assign iq_pc             = entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h4000_0060;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        iq_full;
  logic        iq_push;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] sb[$];

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_mem_resp    (instr_mem_resp),
    .instr_mem_rdata   (instr_mem_rdata),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .iq_full           (iq_full),
    .iq_push           (iq_push),
    .iq_instr          (iq_instr),
    .iq_pc             (iq_pc),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, then check its address
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (!instr_read && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_read"}, {31'd0, instr_read}, 32'd1);
    check({tag, "_addr"}, instr_mem_address, exp_addr);
  endtask

  // One-cycle response pulse, optionally with a coincident redirect
  task automatic respond(input string tag, input logic [31:0] addr, input bit push_exp,
                         input bit redir, input logic [31:0] rpc);
    instr_mem_resp  = 1'b1;
    instr_mem_rdata = mem_word(addr);
    redirect_valid  = redir;
    redirect_pc     = rpc;
    if (push_exp) sb.push_back({addr, mem_word(addr)});
    #1;
    check({tag, "_push"}, {31'd0, iq_push}, {31'd0, push_exp});
    tick();
    instr_mem_resp  = 1'b0;
    instr_mem_rdata = 32'd0;
    redirect_valid  = 1'b0;
  endtask

  // Scoreboard consumer: every push must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && iq_push) begin
      if (sb.size() == 0) begin
        check("push_unexpected", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("iq_pc", iq_pc, e[63:32]);
        check("iq_instr", iq_instr, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    instr_mem_resp  = 1'b0;
    instr_mem_rdata = 32'd0;
    iq_full         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    tick();
    tick();
    check("rst_read", {31'd0, instr_read}, 32'd0);
    check("rst_push", {31'd0, iq_push}, 32'd0);
    check("rst_addr", instr_mem_address, RESET_PC);
    rst = 1'b0;

    // T1: three sequential fetches, response one cycle after request
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = RESET_PC + 32'(4 * i);
      wait_req("t1", a);
      tick();
      respond("t1", a, 1'b1, 1'b0, 32'd0);
    end

    // T2: iq_full blocks issue after reset
    rst     = 1'b1;
    iq_full = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0 || i == 9) check("t2_blocked", {31'd0, instr_read}, 32'd0);
    end
    iq_full = 1'b0;
    tick();
    check("t2_issue", {31'd0, instr_read}, 32'd1);
    check("t2_addr", instr_mem_address, RESET_PC);

    // T3: redirect while request waits; address holds, response dropped
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000_1000;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_addr", instr_mem_address, RESET_PC);
      check("t3_hold_read", {31'd0, instr_read}, 32'd1);
    end
    respond("t3", RESET_PC, 1'b0, 1'b0, 32'd0);
    wait_req("t3_next", 32'h4000_1000);

    // T4: redirect coincident with response
    respond("t4", 32'h4000_1000, 1'b0, 1'b1, 32'h4000_2000);
    wait_req("t4_next", 32'h4000_2000);
    respond("t4_ok", 32'h4000_2000, 1'b1, 1'b0, 32'd0);

    // T5: two redirects during DROP, last one wins
    wait_req("t5_a", 32'h4000_2004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    check("t5_hold_addr", instr_mem_address, 32'h4000_2004);
    respond("t5_drop", 32'h4000_2004, 1'b0, 1'b0, 32'd0);
    wait_req("t5_b", 32'h0000_0200);
    respond("t5_b", 32'h0000_0200, 1'b1, 1'b0, 32'd0);
    wait_req("t5_c", 32'h0000_0204);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    respond("t5_c", 32'h0000_0204, 1'b0, 1'b0, 32'd0);
    wait_req("t5_align", 32'h0000_0200);

    // T6: wrap at top of address space, then reset mid-request
    respond("t6_jump", 32'h0000_0200, 1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_req("t6_top", 32'hFFFF_FFFC);
    respond("t6_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd0);
    wait_req("t6_wrap", 32'h0000_0000);
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    tick();
    check("t6_rst_read", {31'd0, instr_read}, 32'd0);
    check("t6_rst_addr", instr_mem_address, RESET_PC);
    rst             = 1'b0;
    redirect_valid  = 1'b0;
    instr_mem_resp  = 1'b1;
    instr_mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t6_stale_push", {31'd0, iq_push}, 32'd0);
    tick();
    instr_mem_resp = 1'b0;
    wait_req("t6_restart", RESET_PC);
    respond("t6_restart", RESET_PC, 1'b1, 1'b0, 32'd0);

    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
